altr_hps_latch_wr_ctrl: RTL and testbench
=========================================

ALTR_HPS_LATCH_WR_CTRL -- requirements
Module: altr_hps_latch_wr_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data bits per latch row.
REQ-002 SHALL have parameter DEPTH, default 4, number of latch rows (2..16).
REQ-003 SHALL have parameter OPEN_CYC, default 2, cycles a row enable is held open (1..15).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port wr_valid, input, 1, write request valid.
REQ-007 SHALL have port wr_ready, output, 1, controller can accept a request.
REQ-008 SHALL have port wr_addr, input, $clog2(DEPTH), target row.
REQ-009 SHALL have port wr_data, input, DWIDTH, write data.
REQ-010 SHALL have port wr_done, output, 1, one-cycle pulse at write completion.
REQ-011 SHALL have port wr_err, output, 1, one-cycle pulse for an out-of-range address.
REQ-012 SHALL have port lat_d, output, DWIDTH (+1 with parity), data bus to all latch rows.
REQ-013 SHALL have port lat_e_n, output, DEPTH, per-row active-low transparent enable.
REQ-014 SHALL have port lat_vld, output, DEPTH, per-row "written since reset" flags.

Function
REQ-015 SHALL run FSM IDLE -> SETUP -> OPEN -> HOLD -> IDLE.
REQ-016 SHALL assert wr_ready only in IDLE; transfer occurs when wr_valid and wr_ready are both high at the clock edge.
REQ-017 SHALL, on transfer, register wr_addr/wr_data and enter SETUP; lat_d is updated at the transfer edge, and all lat_e_n stay high in SETUP (one cycle).
REQ-018 SHALL in OPEN drive lat_e_n[addr] low, all other bits high, for exactly OPEN_CYC cycles, with a down-counter loaded at SETUP exit.
REQ-019 SHALL in HOLD drive all lat_e_n high and keep lat_d unchanged for one cycle; then pulse wr_done and set lat_vld[addr] at the HOLD->IDLE edge.
REQ-020 SHALL hold lat_d stable from SETUP entry through HOLD exit; lat_d keeps its last value while in IDLE.
REQ-021 SHALL give latency: transfer at edge T; lat_e_n low at T+1..T+OPEN_CYC; wr_done high in cycle T+OPEN_CYC+2; wr_ready high again in the same cycle.
REQ-022 SHALL keep at most one lat_e_n bit low at any time and none outside OPEN.
REQ-023 SHALL treat wr_addr >= DEPTH at transfer as an error: pulse wr_err for the next cycle, stay in IDLE, and leave lat_d, lat_e_n, and lat_vld unchanged.
REQ-024 SHALL ignore wr_valid, wr_addr, and wr_data outside IDLE, with no queuing.
REQ-025 SHALL allow rewriting an already valid row; lat_vld remains set.

Reset
REQ-026 SHALL on rst force lat_e_n to all-ones, lat_d to 0, lat_vld to 0, wr_done to 0, wr_err to 0, the counter to 0, and the FSM to IDLE.
REQ-027 SHALL take reset priority over any state: reset asserted during OPEN closes the enable at that edge, with no wr_done and no lat_vld update.
REQ-028 SHALL hold wr_ready low while rst is high and assert it in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL support macro ALTR_HPS_LATCH_WR_PARITY_EN: when defined, lat_d is DWIDTH+1 bits and its MSB is the even parity (XOR) of wr_data, registered with the data.
REQ-030 SHALL, without ALTR_HPS_LATCH_WR_PARITY_EN, make lat_d exactly DWIDTH bits with no parity logic.

Structure
REQ-031 SHALL define the FSM state enum and the SETUP and HOLD cycle constants (both 1) in shared package altr_hps_latch_wr_pkg.
REQ-032 SHALL place the registered active-low one-hot row decoder, gated by the OPEN state, in sub-module altr_hps_latch_wr_dec.

Verification
REQ-033 SHALL cover a basic write with OPEN_CYC=2: addr=1, data=0xA5 transferred at T -> lat_d=0xA5 from T, lat_e_n=4'b1101 at T+1..T+2, wr_done at T+4, lat_vld=4'b0010.
REQ-034 SHALL cover back-to-back requests: wr_valid held high with addr 0 then 3 -> second transfer only when wr_ready returns, no enable overlap, and lat_vld=4'b1001.
REQ-035 SHALL cover a range error with DEPTH=3: addr=3 -> wr_err for one cycle, lat_e_n stays 3'b111, and no wr_done.
REQ-036 SHALL cover reset mid-OPEN: rst asserted in the first OPEN cycle -> lat_e_n all-ones and lat_d=0 at the next edge, lat_vld=0, and no wr_done.
REQ-037 SHALL cover parity with the macro defined: data=0x07 -> lat_d=9'h107; data=0x03 -> lat_d=9'h003.

Source files
------------

// File: rtl/altr_hps_latch_wr_pkg.sv
// Package: altr_hps_latch_wr_pkg
// Shared definitions for the latch-array write controller.
//   wr_state_e : controller FSM states (IDLE -> SETUP -> OPEN -> HOLD -> IDLE)
//   SETUP_CYC  : cycles lat_d settles before an enable opens
//   HOLD_CYC   : cycles lat_d is held after the enable closes
//   CNT_W      : width of the phase down-counter (covers OPEN_CYC up to 15)
//   PAR_W      : extra lat_d bits; 1 when ALTR_HPS_LATCH_WR_PARITY_EN is defined
package altr_hps_latch_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_OPEN  = 2'd2,
    ST_HOLD  = 2'd3
  } wr_state_e;

  localparam int SETUP_CYC = 1;
  localparam int HOLD_CYC  = 1;
  localparam int CNT_W     = 4;

`ifdef ALTR_HPS_LATCH_WR_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/altr_hps_latch_wr_dec.sv
// Module: altr_hps_latch_wr_dec
// Registered active-low one-hot row decoder. A row enable is driven low only
// while the controller is (next cycle) in OPEN; all rows are closed otherwise.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset, closes every row
//   state_nxt : controller next state; the decoder registers against it so the
//               enable changes on the same edge the FSM enters/leaves OPEN
//   addr      : latched target row
//   lat_e_n   : per-row active-low transparent enable
module altr_hps_latch_wr_dec
  import altr_hps_latch_wr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  wr_state_e        state_nxt,
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] lat_e_n
);

  logic open_nxt;
  assign open_nxt = (state_nxt == ST_OPEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_e_n <= '1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        lat_e_n[i] <= !(open_nxt && (32'(addr) == 32'(i)));
      end
    end
  end

endmodule

// File: rtl/altr_hps_latch_wr_ctrl.sv
// Module: altr_hps_latch_wr_ctrl
// Write controller for an array of DEPTH transparent latch rows sharing one
// data bus. A write sets up lat_d, opens one row enable for OPEN_CYC cycles,
// then holds lat_d one more cycle before completing.
// Optional feature macro: ALTR_HPS_LATCH_WR_PARITY_EN adds an even-parity MSB
// to lat_d.
// Handshake: wr_ready is high only in IDLE (and never during rst); a request
// transfers on a rising edge where wr_valid && wr_ready. The request inputs
// are ignored at all other times, with no queuing.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_valid/wr_ready : request handshake
//   wr_addr, wr_data  : target row and data, captured at transfer
//   wr_done           : one-cycle pulse when a write completes
//   wr_err            : one-cycle pulse after an out-of-range transfer
//   lat_d             : data bus to all rows (plus parity MSB when enabled)
//   lat_e_n           : per-row active-low enables
//   lat_vld           : per-row written-since-reset flags
// The FSM state is available as the internal signal 'state'.
module altr_hps_latch_wr_ctrl
  import altr_hps_latch_wr_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 4,
  parameter int OPEN_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [DWIDTH-1:0]         wr_data,
  output logic                      wr_done,
  output logic                      wr_err,
  output logic [DWIDTH+PAR_W-1:0]   lat_d,
  output logic [DEPTH-1:0]          lat_e_n,
  output logic [DEPTH-1:0]          lat_vld
);

  localparam int AW = $clog2(DEPTH);

  wr_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [AW-1:0]    addr_q;
  logic             in_range;
  logic             xfer_ok, xfer_err, done_nxt;

  assign wr_ready = (state == ST_IDLE) && !rst;
  assign in_range = (32'(wr_addr) < 32'(DEPTH));

  // Each phase loads the counter with its length minus one on entry and
  // advances when the counter reaches zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    xfer_ok   = 1'b0;
    xfer_err  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_valid && wr_ready) begin
          if (in_range) begin
            xfer_ok   = 1'b1;
            state_nxt = ST_SETUP;
            cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          end else begin
            xfer_err = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_OPEN;
          cnt_nxt   = CNT_W'(OPEN_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_OPEN: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      lat_d   <= '0;
      lat_vld <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_done <= done_nxt;
      wr_err  <= xfer_err;
      if (xfer_ok) begin
        addr_q <= wr_addr;
`ifdef ALTR_HPS_LATCH_WR_PARITY_EN
        lat_d  <= {^wr_data, wr_data};
`else
        lat_d  <= wr_data;
`endif
      end
      for (int i = 0; i < DEPTH; i++) begin
        lat_vld[i] <= lat_vld[i] | (done_nxt && (32'(addr_q) == 32'(i)));
      end
    end
  end

  altr_hps_latch_wr_dec #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dec (
    .clk       (clk),
    .rst       (rst),
    .state_nxt (state_nxt),
    .addr      (addr_q),
    .lat_e_n   (lat_e_n)
  );

endmodule

// File: tb/tb_altr_hps_latch_wr_ctrl.sv
module tb_altr_hps_latch_wr_ctrl;

`ifdef ALTR_HPS_LATCH_WR_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam int OPEN_CYC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic          wr_valid = 1'b0;
  logic [1:0]    wr_addr  = '0;
  logic [7:0]    wr_data  = '0;
  logic          wr_ready, wr_done, wr_err;
  logic [LW-1:0] lat_d;
  logic [3:0]    lat_e_n, lat_vld;

  // DEPTH=3 instance for the range-error case
  logic          wr_valid3 = 1'b0;
  logic [1:0]    wr_addr3  = '0;
  logic [7:0]    wr_data3  = '0;
  logic          wr_ready3, wr_done3, wr_err3;
  logic [LW-1:0] lat_d3;
  logic [2:0]    lat_e_n3, lat_vld3;

  altr_hps_latch_wr_ctrl #(.DWIDTH(8), .DEPTH(4), .OPEN_CYC(OPEN_CYC)) u_dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_err(wr_err),
    .lat_d(lat_d), .lat_e_n(lat_e_n), .lat_vld(lat_vld)
  );

  altr_hps_latch_wr_ctrl #(.DWIDTH(8), .DEPTH(3), .OPEN_CYC(OPEN_CYC)) u_dut3 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
    .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_done(wr_done3), .wr_err(wr_err3),
    .lat_d(lat_d3), .lat_e_n(lat_e_n3), .lat_vld(lat_vld3)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       par;
    logic [3:0] en;
    logic [3:0] vld;
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_valid3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready_low", 32'(wr_ready), 32'd0);
    chk("rst_e_n", 32'(lat_e_n), 32'hF);
    chk("rst_lat_d", 32'(lat_d), 32'd0);
    chk("rst_vld", 32'(lat_vld), 32'd0);
    chk("rst_done", 32'(wr_done), 32'd0);
    chk("rst_err", 32'(wr_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_ready3", 32'(wr_ready3), 32'd1);
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the
  // wr_done cycle (DUT idle again).
  task automatic do_write(input logic [1:0] a, input logic [7:0] d,
                          input logic [LW-1:0] exp_d, input logic [3:0] en,
                          input logic [3:0] vld);
    chk("wr_ready_idle", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = ~d;
    chk("setup_lat_d", 32'(lat_d), 32'(exp_d));
    chk("setup_e_n", 32'(lat_e_n), 32'hF);
    chk("setup_ready", 32'(wr_ready), 32'd0);
    for (int k = 0; k < OPEN_CYC; k++) begin
      @(negedge clk);
      chk("open_e_n", 32'(lat_e_n), 32'(en));
      chk("open_done", 32'(wr_done), 32'd0);
    end
    @(negedge clk);
    chk("hold_e_n", 32'(lat_e_n), 32'hF);
    chk("hold_lat_d", 32'(lat_d), 32'(exp_d));
    chk("hold_done", 32'(wr_done), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(wr_done), 32'd1);
    chk("done_ready", 32'(wr_ready), 32'd1);
    chk("done_vld", 32'(lat_vld), 32'(vld));
    chk("done_lat_d", 32'(lat_d), 32'(exp_d));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [LW-1:0] exp_d;
    int first0, first3, done_cnt, overlap, drop, err_cnt;

    // addr, data, parity(hand), open-phase lat_e_n, lat_vld after done
    vecs[0] = '{2'd1, 8'hA5, 1'b0, 4'b1101, 4'b0010};
    vecs[1] = '{2'd3, 8'h3C, 1'b0, 4'b0111, 4'b1010};
    vecs[2] = '{2'd0, 8'h07, 1'b1, 4'b1110, 4'b1011};
    vecs[3] = '{2'd1, 8'h03, 1'b0, 4'b1101, 4'b1011};
    vecs[4] = '{2'd2, 8'hFF, 1'b0, 4'b1011, 4'b1111};

    do_reset();

    for (int i = 0; i < 5; i++) begin
`ifdef ALTR_HPS_LATCH_WR_PARITY_EN
      exp_d = {vecs[i].par, vecs[i].data};
`else
      exp_d = vecs[i].data;
`endif
      do_write(vecs[i].addr, vecs[i].data, exp_d, vecs[i].en, vecs[i].vld);
    end
    @(negedge clk);
    chk("idle_done_clear", 32'(wr_done), 32'd0);
    chk("idle_lat_d_kept", 32'(lat_d[7:0]), 32'hFF);

    // Reset during the first OPEN cycle
    wr_valid = 1'b1;
    wr_addr  = 2'd2;
    wr_data  = 8'hC3;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("mid_open_e_n", 32'(lat_e_n), 32'b1011);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_e_n", 32'(lat_e_n), 32'hF);
    chk("mid_rst_lat_d", 32'(lat_d), 32'd0);
    chk("mid_rst_vld", 32'(lat_vld), 32'd0);
    chk("mid_rst_done", 32'(wr_done), 32'd0);
    chk("mid_rst_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_back", 32'(wr_ready), 32'd1);
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (wr_done) done_cnt++;
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    chk("mid_rst_vld_after", 32'(lat_vld), 32'd0);

    // Back-to-back: wr_valid held high, addr 0 then 3
    wr_valid = 1'b1;
    wr_addr  = 2'd0;
    wr_data  = 8'h11;
    @(negedge clk);
    wr_addr = 2'd3;
    wr_data = 8'h22;
    first0 = -1; first3 = -1; done_cnt = 0; overlap = 0; drop = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (drop == 1) begin
        wr_valid = 1'b0;
        drop = 2;
      end
      if (lat_e_n == 4'b1110 && first0 < 0) first0 = c;
      if (lat_e_n == 4'b0111 && first3 < 0) first3 = c;
      if ($countones(~lat_e_n) > 1) overlap++;
      if (c == 3) chk("b2b_busy_data_ignored", 32'(lat_d[7:0]), 32'h11);
      if (wr_done) begin
        done_cnt++;
        if (drop == 0) drop = 1;
      end
    end
    wr_valid = 1'b0;
    chk("b2b_first0", 32'(first0), 32'd1);
    chk("b2b_first3", 32'(first3), 32'd6);
    chk("b2b_overlap", 32'(overlap), 32'd0);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b_vld", 32'(lat_vld), 32'b1001);
    chk("b2b_lat_d", 32'(lat_d[7:0]), 32'h22);

    // Range error on the DEPTH=3 instance
    wr_valid3 = 1'b1;
    wr_addr3  = 2'd3;
    wr_data3  = 8'h99;
    @(negedge clk);
    wr_valid3 = 1'b0;
    chk("err_pulse", 32'(wr_err3), 32'd1);
    chk("err_e_n", 32'(lat_e_n3), 32'b111);
    chk("err_lat_d", 32'(lat_d3), 32'd0);
    chk("err_ready", 32'(wr_ready3), 32'd1);
    err_cnt = 0; done_cnt = 0; overlap = 0;
    repeat (4) begin
      @(negedge clk);
      if (wr_err3) err_cnt++;
      if (wr_done3) done_cnt++;
      if (lat_e_n3 != 3'b111) overlap++;
    end
    chk("err_one_cycle", 32'(err_cnt), 32'd0);
    chk("err_no_done", 32'(done_cnt), 32'd0);
    chk("err_e_n_closed", 32'(overlap), 32'd0);
    chk("err_vld", 32'(lat_vld3), 32'd0);

    // DEPTH=3 top row still writable
    wr_valid3 = 1'b1;
    wr_addr3  = 2'd2;
    wr_data3  = 8'h44;
    @(negedge clk);
    wr_valid3 = 1'b0;
    @(negedge clk);
    chk("d3_open_e_n", 32'(lat_e_n3), 32'b011);
    repeat (3) @(negedge clk);
    chk("d3_done", 32'(wr_done3), 32'd1);
    chk("d3_vld", 32'(lat_vld3), 32'b100);
    chk("d3_err_clear", 32'(wr_err3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
